// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, default widths,
// requester indices and the round-robin priority state type.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 3;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_SLL = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_SRL = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_SRA = 3'd7;

  localparam int REQ_CORE = 0;
  localparam int REQ_DBG  = 1;

  typedef enum logic {
    PRI_CORE = 1'b0,
    PRI_DBG  = 1'b1
  } pri_state_e;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from elig; the
// priority pointer moves to the loser after every grant.
//
//  state    | meaning
//  PRI_CORE | requester 0 (core) wins a tie
//  PRI_DBG  | requester 1 (debug/DMA) wins a tie
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  pri_state_e r_state;
  pri_state_e w_state_nxt;

  // Priority pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= PRI_CORE;
    else     r_state <= w_state_nxt;
  end

  // Grant selection and pointer advance to the non-granted requester
  always_comb begin
    grant       = 2'b00;
    w_state_nxt = r_state;
    if (elig == 2'b11) begin
      grant = (r_state == PRI_DBG) ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
    if (grant[0])      w_state_nxt = PRI_DBG;
    else if (grant[1]) w_state_nxt = PRI_CORE;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between the core execute stage
// (requester 0) and the debug/DMA port (requester 1). One op per cycle,
// results land in a one-entry response buffer per requester.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data0,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data0;
  logic [DATA_W-1:0] r_rsp_data1;
  logic [CNT_W-1:0]  r_gnt_cnt0;
  logic [CNT_W-1:0]  r_gnt_cnt1;
  logic [1:0]        w_elig;
  logic [1:0]        w_grant;

  // A full buffer that drains this cycle frees its slot. Masking with rst
  // keeps the ALU inputs at zero while reset is held.
  assign w_elig = req_valid & (~r_rsp_valid | rsp_ready) & {2{~rst}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .elig  (w_elig),
    .grant (w_grant)
  );

  assign req_ready = w_grant;

  // ALU operand mux; idle cycles drive ADD 0+0 to avoid X and toggling
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (w_grant[REQ_CORE]) begin
      alu_op = req_op0;
      alu_a  = req_a0;
      alu_b  = req_b0;
    end else if (w_grant[REQ_DBG]) begin
      alu_op = req_op1;
      alu_a  = req_a1;
      alu_b  = req_b1;
    end
  end

  // Requester 0 response buffer; a same-cycle load wins over a drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid[REQ_CORE] <= 1'b0;
      r_rsp_data0           <= '0;
    end else if (w_grant[REQ_CORE]) begin
      r_rsp_valid[REQ_CORE] <= 1'b1;
      r_rsp_data0           <= alu_result;
    end else if (rsp_ready[REQ_CORE]) begin
      r_rsp_valid[REQ_CORE] <= 1'b0;
    end
  end

  // Requester 1 response buffer; a same-cycle load wins over a drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid[REQ_DBG] <= 1'b0;
      r_rsp_data1          <= '0;
    end else if (w_grant[REQ_DBG]) begin
      r_rsp_valid[REQ_DBG] <= 1'b1;
      r_rsp_data1          <= alu_result;
    end else if (rsp_ready[REQ_DBG]) begin
      r_rsp_valid[REQ_DBG] <= 1'b0;
    end
  end

  // Accepted-request counters, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else begin
      if (w_grant[REQ_CORE]) r_gnt_cnt0 <= r_gnt_cnt0 + CNT_W'(1);
      if (w_grant[REQ_DBG])  r_gnt_cnt1 <= r_gnt_cnt1 + CNT_W'(1);
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data0 = r_rsp_data0;
  assign rsp_data1 = r_rsp_data1;
  assign gnt_cnt0  = r_gnt_cnt0;
  assign gnt_cnt1  = r_gnt_cnt1;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU on the shared port.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data0, rsp_data1;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [31:0] gnt_cnt0, gnt_cnt1;

  int n_checks;
  int n_errors;

  alu_share_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data0  (rsp_data0),
    .rsp_data1  (rsp_data1),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a + ~alu_b + 32'd1;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SLL:  alu_result = alu_a << alu_b[4:0];
      OP_SRL:  alu_result = alu_a >> alu_b[4:0];
      default: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
    endcase
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  rdy;
    logic [2:0]  op0;
    logic [31:0] a0, b0;
    logic [2:0]  op1;
    logic [31:0] a1, b1;
    logic [1:0]  exp_rr;
    logic [31:0] exp_alu_b;
    logic [1:0]  exp_rv;
    logic [31:0] exp_d0, exp_d1, exp_c0, exp_c1;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [1:0] valid, logic [1:0] rdy,
                              logic [2:0] op0, logic [31:0] a0, logic [31:0] b0,
                              logic [2:0] op1, logic [31:0] a1, logic [31:0] b1,
                              logic [1:0] exp_rr, logic [31:0] exp_alu_b,
                              logic [1:0] exp_rv, logic [31:0] exp_d0, logic [31:0] exp_d1,
                              logic [31:0] exp_c0, logic [31:0] exp_c1);
    vec_t v;
    v.valid = valid; v.rdy = rdy;
    v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.exp_rr = exp_rr; v.exp_alu_b = exp_alu_b; v.exp_rv = exp_rv;
    v.exp_d0 = exp_d0; v.exp_d1 = exp_d1; v.exp_c0 = exp_c0; v.exp_c1 = exp_c1;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            valid  rdy    op0     a0            b0            op1     a1            b1            rr     alu_b         rv     d0            d1            c0  c1
    vecs[0]  = mk(2'b01, 2'b11, OP_ADD, 32'd5,        32'd3,        OP_ADD, 32'd0,        32'd0,        2'b01, 32'd3,        2'b01, 32'd8,        32'd0,        1,  0);
    vecs[1]  = mk(2'b10, 2'b11, OP_ADD, 32'd0,        32'd0,        OP_SRA, 32'h80000000, 32'h24,       2'b10, 32'h24,       2'b10, 32'd8,        32'hF8000000, 1,  1);
    vecs[2]  = mk(2'b11, 2'b11, OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, OP_OR,  32'h0F,       32'hF0,       2'b01, 32'hFF00FF00, 2'b01, 32'hF000F000, 32'hF8000000, 2,  1);
    vecs[3]  = mk(2'b11, 2'b11, OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, OP_OR,  32'h0F,       32'hF0,       2'b10, 32'hF0,       2'b10, 32'hF000F000, 32'hFF,       2,  2);
    vecs[4]  = mk(2'b11, 2'b11, OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, OP_OR,  32'h0F,       32'hF0,       2'b01, 32'h0F0F0F0F, 2'b01, 32'hF0F00F0F, 32'hFF,       3,  2);
    vecs[5]  = mk(2'b11, 2'b11, OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, OP_SLL, 32'd1,        32'd31,       2'b10, 32'd31,       2'b10, 32'hF0F00F0F, 32'h80000000, 3,  3);
    vecs[6]  = mk(2'b11, 2'b10, OP_ADD, 32'd100,      32'd23,       OP_SLL, 32'd1,        32'd31,       2'b01, 32'd23,       2'b01, 32'd123,      32'h80000000, 4,  3);
    vecs[7]  = mk(2'b11, 2'b10, OP_ADD, 32'd100,      32'd23,       OP_SUB, 32'd7,        32'd9,        2'b10, 32'd9,        2'b11, 32'd123,      32'hFFFFFFFE, 4,  4);
    vecs[8]  = mk(2'b11, 2'b10, OP_ADD, 32'd100,      32'd23,       OP_SRL, 32'h80000000, 32'd4,        2'b10, 32'd4,        2'b11, 32'd123,      32'h08000000, 4,  5);
    vecs[9]  = mk(2'b11, 2'b11, OP_OR,  32'hA,        32'h5,        OP_SRL, 32'h80000000, 32'd4,        2'b01, 32'h5,        2'b01, 32'hF,        32'h08000000, 5,  5);
    vecs[10] = mk(2'b01, 2'b11, OP_SUB, 32'd10,       32'd1,        OP_ADD, 32'd0,        32'd0,        2'b01, 32'd1,        2'b01, 32'd9,        32'h08000000, 6,  5);
    vecs[11] = mk(2'b01, 2'b11, OP_SUB, 32'd10,       32'd2,        OP_ADD, 32'd0,        32'd0,        2'b01, 32'd2,        2'b01, 32'd8,        32'h08000000, 7,  5);
    vecs[12] = mk(2'b01, 2'b11, OP_SUB, 32'd10,       32'd3,        OP_ADD, 32'd0,        32'd0,        2'b01, 32'd3,        2'b01, 32'd7,        32'h08000000, 8,  5);
    vecs[13] = mk(2'b01, 2'b11, OP_SUB, 32'd0,        32'd1,        OP_ADD, 32'd0,        32'd0,        2'b01, 32'd1,        2'b01, 32'hFFFFFFFF, 32'h08000000, 9,  5);
    vecs[14] = mk(2'b00, 2'b11, OP_SUB, 32'd0,        32'd1,        OP_ADD, 32'd7,        32'd7,        2'b00, 32'd0,        2'b00, 32'hFFFFFFFF, 32'h08000000, 9,  5);

    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_op0 = '0; req_op1 = '0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("reset rsp_data0", rsp_data0, 32'd0);
    chk("reset rsp_data1", rsp_data1, 32'd0);
    chk("reset gnt_cnt0", gnt_cnt0, 32'd0);
    chk("reset gnt_cnt1", gnt_cnt1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      req_valid = vecs[i].valid;
      rsp_ready = vecs[i].rdy;
      req_op0 = vecs[i].op0; req_a0 = vecs[i].a0; req_b0 = vecs[i].b0;
      req_op1 = vecs[i].op1; req_a1 = vecs[i].a1; req_b1 = vecs[i].b1;
      #1;
      chk($sformatf("v%0d req_ready", i), {30'd0, req_ready}, {30'd0, vecs[i].exp_rr});
      chk($sformatf("v%0d alu_b", i), alu_b, vecs[i].exp_alu_b);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), {30'd0, rsp_valid}, {30'd0, vecs[i].exp_rv});
      chk($sformatf("v%0d rsp_data0", i), rsp_data0, vecs[i].exp_d0);
      chk($sformatf("v%0d rsp_data1", i), rsp_data1, vecs[i].exp_d1);
      chk($sformatf("v%0d gnt_cnt0", i), gnt_cnt0, vecs[i].exp_c0);
      chk($sformatf("v%0d gnt_cnt1", i), gnt_cnt1, vecs[i].exp_c1);
      @(negedge clk);
    end

    // Reset mid-operation: grant requester 0 so the pointer favours 1,
    // then assert reset between edges and confirm the pointer is back at 0.
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    req_op0 = OP_ADD; req_a0 = 32'd1; req_b0 = 32'd2;
    req_op1 = OP_XOR; req_a1 = 32'h55; req_b1 = 32'hAA;
    @(posedge clk);
    #1;
    chk("pre-reset rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("pre-reset rsp_data0", rsp_data0, 32'd3);
    req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    chk("mid reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("mid reset gnt_cnt0", gnt_cnt0, 32'd0);
    chk("mid reset gnt_cnt1", gnt_cnt1, 32'd0);
    chk("mid reset req_ready", {30'd0, req_ready}, 32'd0);
    chk("mid reset alu_op", {29'd0, alu_op}, 32'd0);
    chk("mid reset alu_a", alu_a, 32'd0);
    chk("mid reset alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post reset first grant", {30'd0, req_ready}, 32'd1);
    chk("post reset alu_a", alu_a, 32'd1);
    @(posedge clk);
    #1;
    chk("post reset rsp_data0", rsp_data0, 32'd3);
    chk("post reset gnt_cnt0", gnt_cnt0, 32'd1);
    @(negedge clk);
    #1;
    chk("post reset second grant", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    #1;
    chk("post reset rsp_data1", rsp_data1, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single combinational 32-bit ALU (3-bit op: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA) between two requesters: requester 0 is the core execute stage, requester 1 is the debug/DMA port.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one ALU operation per cycle; each result is registered into a per-requester one-entry response buffer.
- The ALU is instantiated outside this block; this block drives the ALU's operand and op inputs and samples its result.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 3, ALU op code width.
- CNT_W, 32, width of the per-requester grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle (one-hot or zero).
- req_op0 / req_op1  in  OP_W  ALU op per requester.
- req_a0 / req_a1  in  DATA_W  operand A per requester.
- req_b0 / req_b1  in  DATA_W  operand B per requester.
- rsp_valid  out  2  response buffer i holds a result.
- rsp_ready  in  2  requester i consumes its response.
- rsp_data0 / rsp_data1  out  DATA_W  registered result per requester.
- alu_op  out  OP_W  to ALU.
- alu_a  out  DATA_W  to ALU.
- alu_b  out  DATA_W  to ALU.
- alu_result  in  DATA_W  from ALU (combinational).
- gnt_cnt0 / gnt_cnt1  out  CNT_W  accepted-request counters.

Behaviour:
- Reset (async, rst=1):
  - rsp_valid=0, rsp_data0/1=0.
  - Priority pointer = 0 (requester 0 first).
  - gnt_cnt0/1=0.
  - Any in-flight result is discarded; no response is produced for it.
- Eligibility: elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A full buffer draining in the same cycle frees its slot.
- Grant (combinational, same cycle):
  - Only one requester eligible: that requester wins.
  - Both eligible: the requester named by the priority pointer wins.
  - req_ready = one-hot grant vector. req_ready may depend on req_valid; req_valid must not depend on req_ready.
- Pointer update: on any grant, at the clock edge, the pointer moves to the non-granted requester. With no grant it holds.
- ALU drive:
  - Grant present: alu_op/alu_a/alu_b = granted requester's fields.
  - No grant: all three are driven to 0 (ADD 0+0), avoiding X propagation and toggling.
- Latency is 1 cycle. A request accepted at edge N gives rsp_valid[i]=1 and rsp_data_i=alu_result, sampled at edge N.
- Response buffer i, at each edge:
  - grant[i]: load, valid=1.
  - else if rsp_ready[i]: valid=0, data holds.
  - else: hold.
- Simultaneous drain and grant on the same requester: the new result replaces the old one, valid stays 1. This gives full throughput of 1 op/cycle per requester when the response side is always ready.
- Requester stall: a requester whose buffer is full and not draining is never granted. The other requester proceeds unimpeded (no head-of-line blocking).
- rsp_data is stable while rsp_valid=1 && rsp_ready=0.
- Counters: gnt_cnt_i increments by 1 on each grant[i] and wraps modulo 2^CNT_W.
- Fairness: under continuous contention with both buffers draining, grants strictly alternate 0,1,0,1 and no requester waits more than 1 cycle.
- Operand width rules: no arithmetic is done here. Shift amount semantics (B[4:0]) and SUB as A + ~B + 1 belong to the ALU; this block passes all DATA_W operand bits unchanged.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_SLL=5, OP_SRL=6, OP_SRA=7.
  - DATA_W and OP_W defaults.
  - Requester index constants REQ_CORE=0, REQ_DBG=1.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, rst, elig[1:0].
  - Outputs: grant[1:0].
  - Owns the priority pointer and its update.
- Response buffers, ALU mux and counters live in the top level.

Test Plan:
- Single op, requester 0: after reset, req_valid=01, ADD a0=5 b0=3, rsp_ready=11.
  - Expect req_ready=01 that cycle.
  - Next cycle rsp_valid=01, rsp_data0=8.
  - gnt_cnt0=1.
- Shift pass-through, requester 1: SRA a1=0x80000000 b1=0x24.
  - Expect alu_b=0x24 driven unchanged.
  - Expect rsp_data1=0xF8000000 (ALU uses b[4:0]=4).
- Contention: both valid continuously for 4 cycles, rsp_ready=11.
  - Expect grants 0,1,0,1.
  - Expect gnt_cnt0=gnt_cnt1=2.
  - Each requester's response appears 1 cycle after its grant.
- Backpressure isolation: rsp0 full with rsp_ready0=0, both valid.
  - Expect req_ready0=0 and requester 1 granted every cycle.
  - After rsp_ready0=1 for one cycle, requester 0 is granted in that same cycle.
- Drain+refill: requester 0 streams SUB 10-1, 10-2, 10-3 with rsp_ready0=1.
  - Expect rsp_valid0 held at 1 across consecutive cycles, with rsp_data0 = 9, 8, 7.
  - Confirm with a sign-wrap case: SUB 0-1 gives 0xFFFFFFFF.
- Reset mid-operation: assert rst asynchronously between the clock edges, right after a grant.
  - Expect rsp_valid=00, counters=0 and alu_* outputs=0 immediately.
  - After release, the first contended grant goes to requester 0.
